// File: rtl/rom_loader.sv
// rom_loader: byte-stream boot loader writing framed, checksummed 16-bit words into instruction ROM
module rom_loader #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int NW = ADDR_W + 1;
  localparam int unsigned MAXN = 1 << ADDR_W;
  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO, RUN, ERR} state_t;
  state_t state;
  logic [7:0] hi;
  logic [ADDR_W:0] n, idx;
  logic [15:0] sum;
  logic xfer;
  logic [15:0] word;
  assign busy = state != RUN && state != ERR;
  assign in_ready = busy;
  assign cpu_reset = state != RUN;
  assign done = state == RUN;
  assign error = state == ERR;
  assign xfer = in_valid && in_ready;
  assign word = {hi, in_data};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HDR_HI;
      hi <= '0;
      n <= '0;
      idx <= '0;
      sum <= '0;
      rom_we <= 1'b0;
      rom_addr <= '0;
      rom_wdata <= '0;
      words_loaded <= '0;
    end else begin
      rom_we <= 1'b0;
      if (xfer) begin
        hi <= in_data;
        case (state)
          HDR_HI: state <= HDR_LO;
          HDR_LO: begin
            n <= NW'(word);
            idx <= '0;
            sum <= word;
            state <= word == 16'd0 ? SUM_HI : (32'(word) > MAXN ? ERR : DATA_HI);
          end
          DATA_HI: state <= DATA_LO;
          DATA_LO: begin
            rom_we <= 1'b1;
            rom_addr <= idx[ADDR_W-1:0];
            rom_wdata <= word;
            words_loaded <= words_loaded + 1'b1;
            sum <= sum + word;
            idx <= idx + 1'b1;
            state <= idx + 1'b1 == n ? SUM_HI : DATA_HI;
          end
          SUM_HI: state <= SUM_LO;
          SUM_LO: state <= word == sum ? RUN : ERR;
          default: state <= state;
        endcase
      end
    end
  end
endmodule
